// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default, counter width and one-hot {L,E,G} result encoding.
package comparator_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH) + 1;

    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_L    = 3'b100;
    localparam res_t RES_E    = 3'b010;
    localparam res_t RES_G    = 3'b001;

    function automatic res_t encode(input logic lt, input logic eq);
        return lt ? RES_L : (eq ? RES_E : RES_G);
    endfunction
endpackage

// File: rtl/cmp_serial_core.sv
// cmp_serial_core: LSB-first bit-serial magnitude compare of operands captured at reset.
// SIGNED_CMP_EN: treat the MSB as a two's-complement sign bit.
module cmp_serial_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output res_t             res,
    output logic             done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sa, sb;
    logic [CNT_W-1:0] cnt;
    logic             flip;
    res_t             res_next;

    // A differing sign bit decides the opposite way from an ordinary magnitude bit.
`ifdef SIGNED_CMP_EN
    assign flip = (cnt == LAST);
`else
    assign flip = 1'b0;
`endif

    assign res_next = (sa[0] ^ sb[0]) ? ((sa[0] ^ flip) ? RES_G : RES_L) : res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sa   <= a;
            sb   <= b;
            cnt  <= '0;
            done <= 1'b0;
            res  <= RES_E;
        end else if (!done) begin
            res  <= res_next;
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            cnt  <= cnt + CNT_W'(1);
            done <= (cnt == LAST);
        end
    end
endmodule

// File: rtl/comparator_32_bit.sv
// comparator_32_bit: parallel and bit-serial magnitude comparators with op-gated one-hot L/E/G.
// SIGNED_CMP_EN: both engines compare in two's complement.
module comparator_32_bit
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             L,
    output logic             E,
    output logic             G
);
    res_t par, ser, sel;
    logic done, lt;

`ifdef SIGNED_CMP_EN
    assign lt = $signed(a) < $signed(b);
`else
    assign lt = a < b;
`endif

    always_ff @(posedge clk) begin
        par <= !rst ? RES_NONE : encode(lt, a == b);
    end

    cmp_serial_core #(.WIDTH(WIDTH)) u_serial (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .res  (ser),
        .done (done)
    );

    // Serial result stays hidden until the full pass has completed.
    assign sel       = mode ? (done ? ser : RES_NONE) : par;
    assign {L, E, G} = sel & {3{op}};
endmodule

// File: tb/tb_comparator_32_bit.sv
// tb_comparator_32_bit: directed vectors with a queue scoreboard checked after every clock edge.
module tb_comparator_32_bit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        L, E, G;

    typedef struct {
        string      name;
        logic [2:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] N = 3'b000, LT = 3'b100, EQ = 3'b010, GT = 3'b001;

    comparator_32_bit dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .op   (op),
        .a    (a),
        .b    (b),
        .L    (L),
        .E    (E),
        .G    (G)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle describes the outputs just after the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                chk_t c;
                c = q.pop_front();
                checks++;
                if ({L, E, G} !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got LEG=%b expected %b (t=%0t)", c.name, {L, E, G}, c.exp, $time);
                end
            end
        end
    end

    task automatic tick(input string nm, input logic [2:0] ex);
        q.push_back('{nm, ex});
        @(negedge clk);
    endtask

    task automatic serial_run(input string nm, input logic [31:0] va, input logic [31:0] vb,
                              input logic [2:0] ex);
        rst  = 1'b0;
        mode = 1'b1;
        op   = 1'b1;
        a    = va;
        b    = vb;
        tick({nm, "_rst"}, N);
        rst = 1'b1;
        for (int i = 1; i < 32; i++) tick({nm, "_pend"}, N);
        tick(nm, ex);
    endtask

    initial begin
        @(negedge clk);
        // Serial with op held low for the whole pass, then enabled.
        mode = 1'b1;
        a    = 32'h9292B292;
        b    = 32'h92929292;
        tick("rst_serial", N);
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) tick("op_low", N);
        op = 1'b1;
        tick("serial_g", GT);
        tick("serial_g_hold", GT);

        // Parallel: one-edge latency, re-sampled every cycle.
        rst  = 1'b0;
        mode = 1'b0;
        tick("rst_par", N);
        rst = 1'b1;
        tick("par_g", GT);
        b = 32'h9292B292;
        tick("par_e", EQ);
        a = 32'h1;
        b = 32'h2;
        tick("par_l", LT);
        a = 32'h0;
        b = 32'h0;
        tick("par_zero", EQ);
        a = 32'hFFFFFFFF;
        b = 32'h0;
`ifdef SIGNED_CMP_EN
        tick("par_max", LT);
`else
        tick("par_max", GT);
`endif

        // Serial boundaries.
`ifdef SIGNED_CMP_EN
        serial_run("msb_override", 32'h00000001, 32'h80000000, GT);
        serial_run("bit31_only", 32'h80000000, 32'h7FFFFFFF, LT);
`else
        serial_run("msb_override", 32'h00000001, 32'h80000000, LT);
        serial_run("bit31_only", 32'h80000000, 32'h7FFFFFFF, GT);
`endif
        serial_run("bit0_only", 32'h00000001, 32'h00000000, GT);
        serial_run("zero_zero", 32'h0, 32'h0, EQ);

        // Operands are captured only at reset; parallel keeps tracking live inputs.
        serial_run("deadbeef", 32'hDEADBEEF, 32'hDEADBEEF, EQ);
        a = 32'h0;
        tick("deadbeef_a0", EQ);
        mode = 1'b0;
`ifdef SIGNED_CMP_EN
        tick("mode_par", GT);
`else
        tick("mode_par", LT);
`endif
        mode = 1'b1;
        tick("mode_ser", EQ);

        // Reset mid-pass restarts with the newly presented operands.
        rst = 1'b0;
        a   = 32'hFF;
        b   = 32'h0;
        tick("abort_rst", N);
        rst = 1'b1;
        for (int i = 1; i < 10; i++) tick("abort_pend", N);
        serial_run("restart", 32'h0, 32'h5, LT);

        // op gates the result without disturbing it.
        op = 1'b0;
        tick("op_off", N);
        op = 1'b1;
        tick("op_on", LT);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/comparator_32_bit.md
Name: comparator_32_bit

Overview:
32-bit magnitude comparator with two selectable engines: a parallel engine that compares the full words every clock, and a bit-serial engine that walks both operands one bit per clock over 32 cycles. It produces one-hot less/equal/greater flags, gated by an output-enable. It is used as an arithmetic-unit building block and for demonstrating serial versus parallel comparison latency.

Parameters:
WIDTH, 32, operand width in bits; the serial engine takes WIDTH cycles.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
mode  in  1  engine select: 0 = parallel, 1 = bit-serial
op  in  1  output enable: 1 = drive result on L/E/G, 0 = force L/E/G low
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
L  out  1  A < B
E  out  1  A == B
G  out  1  A > B

Behaviour:
- All state is updated on the rising edge of clk only. No asynchronous paths except the op output gating.
- Reset (rst=0 at a clock edge):
  - Serial shift registers load a and b.
  - Serial bit counter is cleared to 0 and the serial done flag is cleared.
  - Serial running result is set to "equal".
  - Parallel result register is cleared to 000.
  - L/E/G therefore read 0 during and immediately after reset.
- Parallel engine, every edge with rst=1:
  - The result register captures the full unsigned compare of a and b.
  - Latency is 1 cycle; a and b are re-sampled every cycle.
- Serial engine, every edge with rst=1 while the counter is below WIDTH:
  - Examines the current LSB of the shift registers, i.e. bit i on the i-th edge after reset, LSB first.
  - If the bits differ, the running result becomes G when the a-bit is 1, otherwise L.
  - If the bits are equal, the running result is kept; a higher-order difference overrides a lower-order one.
  - Both shift registers shift right by 1 and the counter increments.
  - When the counter reaches WIDTH the done flag sets. The result and counter then freeze until the next reset.
- Serial operands are captured only at reset. Changes to a/b afterwards do not affect the serial result.
- Both engines run continuously. mode only selects which result drives the outputs, so it may change at any time without corrupting either engine.
- Output mux:
  - mode=0: the parallel result register.
  - mode=1: the serial running result if done=1, else 000.
  - The selected result is then ANDed with op, combinationally.
- Flags are one-hot whenever valid; never more than one of L/E/G is high.
- Reset mid-serial-operation aborts the pass and restarts it with the current a/b; the result is invalid until WIDTH edges after reset release.
- Boundaries: a=b=0 → E; a=0xFFFFFFFF, b=0 → G; a difference only in bit 0 → decided correctly; a difference only in bit 31 → overrides all lower bits.

Optional Feature:
- Macro SIGNED_CMP_EN.
- Defined: both engines compare in two's complement. In the serial engine, on the final bit (MSB) a differing bit pair yields L if the a-bit is 1, else G. The parallel engine uses a signed compare.
- Undefined: unsigned comparison as described above.

Decomposition:
- Package comparator_pkg holds:
  - the WIDTH default;
  - the 3-bit result encoding constants: RES_NONE=000, RES_L=100, RES_E=010, RES_G=001, ordered {L,E,G};
  - the counter width localparam, $clog2(WIDTH)+1.
- Sub-module cmp_serial_core contains the shift registers, counter, done flag and running result. The parallel engine and output mux stay in the top module.

Test Plan:
- a=0x9292B292, b=0x92929292, mode=1, pulse rst low for one edge, op=0 for 32 cycles then op=1 → L/E/G=000 before cycle 32; G=1, L=E=0 from cycle 32 onward.
- Same operands, mode=0, op=1 → G=1 one edge after reset release. Change b to 0x9292B292 → E=1 on the next edge.
- mode=1, a=0x00000001, b=0x80000000 → L=1 after 32 edges (MSB override). With SIGNED_CMP_EN → G=1.
- mode=1, a=b=0xDEADBEEF → E=1 after 32 edges. Changing a to 0 after reset does not change the serial result.
- Serial run with rst pulled low at cycle 10 and a re-loaded as 0x00000000, b=0x00000005 → outputs 000 until 32 edges after release, then L=1.
- op toggled 1→0→1 with a valid result → outputs follow op combinationally; the underlying result is unchanged.
